// File: rtl/riscv_mc_controller.sv
// Multicycle RISC-V main controller: Moore FSM sequencing fetch, decode,
// memory, execute and writeback steps and driving the datapath mux selects.
module riscv_mc_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic [1:0]         alu_op,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         result_src,
    output logic               adr_src,
    output logic               ir_write,
    output logic               reg_write,
    output logic               mem_write,
    output logic               pc_write,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   pc_update;
    logic   branch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // illegal_d is only raised on the DECODE->FETCH abort, so the flag
    // shows up for exactly the one FETCH cycle that follows it.
    always_comb begin
        state_d   = state_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_IALU:      state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_MEMWB, S_ALUWB, S_BEQ:            state_d = S_FETCH;
            S_EXECUTER, S_EXECUTEI, S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        alu_op     = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: adr_src = 1'b1;
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_write   = pc_update | (branch & zero);
    assign illegal_op = illegal_q;
    assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_riscv_mc_controller.sv
// Bench for riscv_mc_controller: directed vector table, hand-written reset
// corner cases, and random instruction streams against a path-based model.
module tb_riscv_mc_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IA  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [1:0] alu_op, alu_src_a, alu_src_b, result_src;
    logic       adr_src, ir_write, reg_write, mem_write, pc_write, illegal_op;
    logic [3:0] state;

    riscv_mc_controller #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .adr_src(adr_src), .ir_write(ir_write),
        .reg_write(reg_write), .mem_write(mem_write), .pc_write(pc_write),
        .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int miss = 0;

    task automatic cmp(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Control word of each step, indexed by step number 0..10.
    int t_asa[11] = '{0, 1, 2, 0, 0, 0, 2, 2, 0, 2, 1};
    int t_asb[11] = '{2, 1, 1, 0, 0, 0, 0, 1, 0, 0, 2};
    int t_rs [11] = '{2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    int t_aop[11] = '{0, 0, 0, 0, 0, 0, 2, 2, 0, 1, 0};
    int t_adr[11] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0};
    int t_irw[11] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int t_rw [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    int t_mw [11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    int t_pcu[11] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    int t_br [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    // Reference model: the current step plus the steps still to come.
    int  cur = 0;
    int  q[$];
    bit  ill_pending = 0;
    bit  exp_ill = 0;

    function automatic bit known(input logic [6:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == IA) || (o == BQ) || (o == JL);
    endfunction

    task automatic model_reset();
        cur = 0;
        q.delete();
        ill_pending = 0;
        exp_ill = 0;
    endtask

    task automatic model_step(input logic [6:0] o, input bit mr);
        int prev;
        prev = cur;
        exp_ill = 0;
        if ((cur == 3 || cur == 5) && !mr) begin
            cur = cur;
        end else if (cur == 0) begin
            q.delete();
            case (o)
                LW:      q = '{1, 2, 3, 4};
                SW:      q = '{1, 2, 5};
                RT:      q = '{1, 6, 8};
                IA:      q = '{1, 7, 8};
                BQ:      q = '{1, 9};
                JL:      q = '{1, 10, 8};
                default: q = '{1};
            endcase
            ill_pending = !known(o);
            cur = q.pop_front();
        end else if (q.size() == 0) begin
            cur = 0;
            exp_ill = (prev == 1) && ill_pending;
        end else begin
            cur = q.pop_front();
        end
    endtask

    task automatic check_all();
        cmp("state", state, cur);
        cmp("alu_op", alu_op, t_aop[cur]);
        cmp("alu_src_a", alu_src_a, t_asa[cur]);
        cmp("alu_src_b", alu_src_b, t_asb[cur]);
        cmp("result_src", result_src, t_rs[cur]);
        cmp("adr_src", adr_src, t_adr[cur]);
        cmp("ir_write", ir_write, t_irw[cur]);
        cmp("reg_write", reg_write, t_rw[cur]);
        cmp("mem_write", mem_write, t_mw[cur]);
        cmp("pc_write", pc_write, t_pcu[cur] | (t_br[cur] & int'(zero)));
        cmp("illegal_op", illegal_op, int'(exp_ill));
    endtask

    function automatic logic [6:0] pick_op();
        int r;
        r = $urandom % 8;
        case (r)
            0: return LW;
            1: return SW;
            2: return RT;
            3: return IA;
            4: return BQ;
            5: return JL;
            default: return 7'($urandom);
        endcase
    endfunction

    typedef struct {
        logic [6:0] op;
        bit         z;
        bit         mr;
        int         st, aop, rw, pcw, adr, mw, ill;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [6:0] o, input bit z, input bit mr, input int st,
                       input int aop, input int rw, input int pcw, input int adr,
                       input int mw, input int ill);
        vec_t v;
        v.op = o; v.z = z; v.mr = mr; v.st = st; v.aop = aop; v.rw = rw;
        v.pcw = pcw; v.adr = adr; v.mw = mw; v.ill = ill;
        tbl.push_back(v);
    endtask

    initial begin
        //   op   z  mr  st aop rw pcw adr mw ill
        add(RT,  1, 0,  0, 0, 0, 1, 0, 0, 0);
        add(RT,  1, 0,  1, 0, 0, 0, 0, 0, 0);
        add(RT,  1, 0,  6, 2, 0, 0, 0, 0, 0);
        add(RT,  1, 0,  8, 0, 1, 0, 0, 0, 0);
        add(LW,  0, 1,  0, 0, 0, 1, 0, 0, 0);
        add(LW,  0, 0,  1, 0, 0, 0, 0, 0, 0);
        add(LW,  0, 0,  2, 0, 0, 0, 0, 0, 0);
        add(LW,  0, 0,  3, 0, 0, 0, 1, 0, 0);
        add(LW,  0, 0,  3, 0, 0, 0, 1, 0, 0);
        add(LW,  0, 0,  3, 0, 0, 0, 1, 0, 0);
        add(LW,  0, 1,  3, 0, 0, 0, 1, 0, 0);
        add(LW,  0, 0,  4, 0, 1, 0, 0, 0, 0);
        add(BQ,  0, 0,  0, 0, 0, 1, 0, 0, 0);
        add(BQ,  1, 0,  1, 0, 0, 0, 0, 0, 0);
        add(BQ,  1, 0,  9, 1, 0, 1, 0, 0, 0);
        add(BQ,  1, 0,  0, 0, 0, 1, 0, 0, 0);
        add(BQ,  0, 0,  1, 0, 0, 0, 0, 0, 0);
        add(BQ,  0, 0,  9, 1, 0, 0, 0, 0, 0);
        add(JL,  0, 0,  0, 0, 0, 1, 0, 0, 0);
        add(JL,  0, 0,  1, 0, 0, 0, 0, 0, 0);
        add(JL,  0, 0, 10, 0, 0, 1, 0, 0, 0);
        add(JL,  0, 0,  8, 0, 1, 0, 0, 0, 0);
        add(BAD, 0, 0,  0, 0, 0, 1, 0, 0, 0);
        add(BAD, 0, 0,  1, 0, 0, 0, 0, 0, 0);
        add(SW,  0, 0,  0, 0, 0, 1, 0, 0, 1);
        add(SW,  0, 0,  1, 0, 0, 0, 0, 0, 0);
        add(SW,  0, 0,  2, 0, 0, 0, 0, 0, 0);
        add(SW,  0, 0,  5, 0, 0, 0, 1, 1, 0);
        add(SW,  0, 1,  5, 0, 0, 0, 1, 1, 0);
        add(IA,  0, 0,  0, 0, 0, 1, 0, 0, 0);
        add(IA,  0, 0,  1, 0, 0, 0, 0, 0, 0);
        add(IA,  0, 0,  7, 2, 0, 0, 0, 0, 0);
        add(IA,  0, 0,  8, 0, 1, 0, 0, 0, 0);

        // Reset state
        repeat (2) @(negedge clk);
        cmp("rst_state", state, 0);
        cmp("rst_illegal", illegal_op, 0);
        cmp("rst_ir_write", ir_write, 1);
        cmp("rst_pc_write", pc_write, 1);
        cmp("rst_mem_write", mem_write, 0);
        rst_n = 1'b1;

        // Directed vector table
        foreach (tbl[i]) begin
            op = tbl[i].op; zero = tbl[i].z; mem_ready = tbl[i].mr;
            #1;
            cmp($sformatf("v%0d_state", i), state, tbl[i].st);
            cmp($sformatf("v%0d_alu_op", i), alu_op, tbl[i].aop);
            cmp($sformatf("v%0d_reg_write", i), reg_write, tbl[i].rw);
            cmp($sformatf("v%0d_pc_write", i), pc_write, tbl[i].pcw);
            cmp($sformatf("v%0d_adr_src", i), adr_src, tbl[i].adr);
            cmp($sformatf("v%0d_mem_write", i), mem_write, tbl[i].mw);
            cmp($sformatf("v%0d_illegal", i), illegal_op, tbl[i].ill);
            @(negedge clk);
        end

        // Async reset in the middle of a MEMWRITE stall
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; op = SW; mem_ready = 1'b0; zero = 1'b0;
        repeat (3) @(negedge clk);
        cmp("stall_state", state, 5);
        cmp("stall_mem_write", mem_write, 1);
        #1 rst_n = 1'b0;
        #1;
        cmp("async_state", state, 0);
        cmp("async_mem_write", mem_write, 0);
        cmp("async_ir_write", ir_write, 1);
        @(negedge clk);
        cmp("held_rst_state", state, 0);
        rst_n = 1'b1; op = BAD; mem_ready = 1'b1;

        // Reset arriving while illegal_op is being shown clears it at once
        repeat (2) @(negedge clk);
        cmp("bad_fetch_state", state, 0);
        cmp("bad_fetch_illegal", illegal_op, 1);
        #1 rst_n = 1'b0;
        #1;
        cmp("rst_clears_illegal", illegal_op, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random instruction streams against the model
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if (cur == 0) op = pick_op();
            zero = 1'($urandom);
            mem_ready = (($urandom % 3) != 0);
            #1;
            check_all();
            if (($urandom % 97) == 0) begin
                #1 rst_n = 1'b0;
                #1;
                model_reset();
                cmp("rnd_async_state", state, 0);
                cmp("rnd_async_illegal", illegal_op, 0);
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(posedge clk);
                model_step(op, mem_ready);
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
